// File: rtl/nes_mem_pkg.sv
// Shared constants for the NES SDRAM request-port arbiter and its loader FIFO.
package nes_mem_pkg;

  localparam int NES_ADDR_BITS   = 22;
  localparam int SDRAM_ADDR_BITS = 25;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_RUN   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/ldr_wr_fifo.sv
// Loader write FIFO of {addr,data} with first-word-fall-through head.
module ldr_wr_fifo
  import nes_mem_pkg::*;
#(
  parameter int C_depth     = 4,
  parameter int C_addr_bits = NES_ADDR_BITS,
  localparam int PW         = $clog2(C_depth)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [C_addr_bits-1:0] push_addr,
  input  logic [7:0]             push_data,
  input  logic                   pop,
  output logic [C_addr_bits-1:0] head_addr,
  output logic [7:0]             head_data,
  output logic                   full,
  output logic                   empty,
  output logic [PW:0]            count
);

  localparam logic [PW-1:0] PTR_ONE  = 1;
  localparam logic [PW:0]   CNT_ONE  = 1;
  localparam logic [PW:0]   CNT_FULL = C_depth[PW:0];

  logic [C_addr_bits+7:0] mem [C_depth];
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic                   do_push;
  logic                   do_pop;

  // push/pop are single-cycle strobes with no back-pressure: a pop on empty is
  // ignored, a push on full is accepted only if a pop frees the slot that cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign {head_addr, head_data} = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= {push_addr, push_data};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count <= count + (do_push ? CNT_ONE : '0) - (do_pop ? CNT_ONE : '0);
    end
  end

endmodule

// File: rtl/nes_mem_port_arbiter.sv
// Arbitrates the single SDRAM request port between the game loader FIFO and the NES core;
// the NES is held in reset until every loaded byte has been written.
module nes_mem_port_arbiter
  import nes_mem_pkg::*;
#(
  parameter int C_fifo_depth = 4,
  parameter int C_addr_bits  = NES_ADDR_BITS,
  parameter int C_ce_phase   = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [1:0]                 i_ce_phase,
  input  logic                       i_load_done,
  input  logic                       i_ldr_write,
  input  logic [C_addr_bits-1:0]     i_ldr_addr,
  input  logic [7:0]                 i_ldr_data,
  input  logic [C_addr_bits-1:0]     i_nes_addr,
  input  logic                       i_nes_read_cpu,
  input  logic                       i_nes_read_ppu,
  input  logic                       i_nes_write,
  input  logic [7:0]                 i_nes_dout,
  output logic [SDRAM_ADDR_BITS-1:0] o_addr,
  output logic                       o_we,
  output logic [7:0]                 o_din,
  output logic                       o_oeA,
  output logic                       o_oeB,
  output logic                       o_dq_drive,
  output logic                       o_nes_reset,
  output logic                       o_fifo_empty,
  output logic                       o_ldr_overflow
);

  localparam int CW  = $clog2(C_fifo_depth) + 1;
  localparam int PAD = SDRAM_ADDR_BITS - C_addr_bits;

  arb_state_t             state;
  logic                   slot;
  logic                   ldr_push;
  logic                   issue_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CW-1:0]          fifo_count;
  logic [C_addr_bits-1:0] head_addr;
  logic [7:0]             head_data;
  logic                   r_we;
  logic [C_addr_bits-1:0] r_addr;
  logic [7:0]             r_din;
  logic                   r_overflow;
  logic                   run;

  assign slot      = (i_ce_phase == 2'(C_ce_phase));
  assign run       = (state == ST_RUN);
  assign ldr_push  = i_ldr_write && !run;
  assign issue_pop = !run && slot && !fifo_empty;

  ldr_wr_fifo #(
    .C_depth     (C_fifo_depth),
    .C_addr_bits (C_addr_bits)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (ldr_push),
    .push_addr (i_ldr_addr),
    .push_data (i_ldr_data),
    .pop       (issue_pop),
    .head_addr (head_addr),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_LOAD;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_din      <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (ldr_push && fifo_full && !issue_pop) r_overflow <= 1'b1;
      // A loader request is latched on a slot and then held until the next slot.
      if (!run && slot) begin
        if (!fifo_empty) begin
          r_we   <= 1'b1;
          r_addr <= head_addr;
          r_din  <= head_data;
        end else begin
          r_we <= 1'b0;
        end
      end
      case (state)
        ST_LOAD:  if (i_load_done) state <= ST_DRAIN;
        ST_DRAIN: begin
          if (!i_load_done)             state <= ST_LOAD;
          else if (slot && fifo_empty) state <= ST_RUN;
        end
        ST_RUN:   if (!i_load_done) state <= ST_LOAD;
        default:  state <= ST_LOAD;
      endcase
    end
  end

  assign o_addr         = run ? {{PAD{1'b0}}, i_nes_addr} : {{PAD{1'b0}}, r_addr};
  assign o_we           = run ? i_nes_write : r_we;
  assign o_din          = run ? i_nes_dout : r_din;
  assign o_oeA          = run && i_nes_read_cpu;
  assign o_oeB          = run && i_nes_read_ppu;
  assign o_dq_drive     = o_we;
  assign o_nes_reset    = !run;
  assign o_fifo_empty   = (fifo_count == '0);
  assign o_ldr_overflow = r_overflow;

endmodule

// File: tb/tb_nes_mem_port_arbiter.sv
// Directed bench for nes_mem_port_arbiter: loader issue timing, overflow, drain and NES pass-through.
module tb_nes_mem_port_arbiter;

  logic        clock;
  logic        reset;
  logic [1:0]  ce_phase;
  logic        load_done;
  logic        ldr_write;
  logic [21:0] ldr_addr;
  logic [7:0]  ldr_data;
  logic [21:0] nes_addr;
  logic        read_cpu;
  logic        read_ppu;
  logic        nes_write;
  logic [7:0]  nes_dout;
  logic [24:0] addr;
  logic        we;
  logic [7:0]  din;
  logic        oe_a;
  logic        oe_b;
  logic        dq_drive;
  logic        nes_reset;
  logic        fifo_empty;
  logic        ldr_overflow;

  int checks = 0;
  int errors = 0;
  logic [29:0] exp_q[$];

  nes_mem_port_arbiter dut (
    .clock          (clock),
    .reset          (reset),
    .i_ce_phase     (ce_phase),
    .i_load_done    (load_done),
    .i_ldr_write    (ldr_write),
    .i_ldr_addr     (ldr_addr),
    .i_ldr_data     (ldr_data),
    .i_nes_addr     (nes_addr),
    .i_nes_read_cpu (read_cpu),
    .i_nes_read_ppu (read_ppu),
    .i_nes_write    (nes_write),
    .i_nes_dout     (nes_dout),
    .o_addr         (addr),
    .o_we           (we),
    .o_din          (din),
    .o_oeA          (oe_a),
    .o_oeB          (oe_b),
    .o_dq_drive     (dq_drive),
    .o_nes_reset    (nes_reset),
    .o_fifo_empty   (fifo_empty),
    .o_ldr_overflow (ldr_overflow)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  // drivers
  task automatic tick(input bit adv);
    @(posedge clock);
    #1;
    if (adv) ce_phase = ce_phase + 2'd1;
  endtask

  task automatic goto_ce(input logic [1:0] c);
    for (int i = 0; i < 4 && ce_phase != c; i++) tick(1);
  endtask

  // tests
  task automatic test_reset();
    reset = 1; ce_phase = 0; load_done = 0; ldr_write = 0; ldr_addr = 0; ldr_data = 0;
    nes_addr = 0; read_cpu = 0; read_ppu = 0; nes_write = 0; nes_dout = 0;
    tick(0); tick(0);
    reset = 0;
    for (int i = 0; i < 4; i++) tick(1);
    checks++; if (nes_reset !== 1'b1) begin errors++; $display("FAIL reset_nes_reset got %0b want 1", nes_reset); end
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset_we got %0b want 0", we); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_fifo_empty got %0b want 1", fifo_empty); end
    checks++; if (ldr_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b want 0", ldr_overflow); end
    checks++; if (addr !== 25'h0 || din !== 8'h0) begin errors++; $display("FAIL reset_addr_din got %h/%h want 0/0", addr, din); end
    checks++; if (oe_a !== 1'b0 || oe_b !== 1'b0 || dq_drive !== 1'b0) begin errors++; $display("FAIL reset_oe_dq got %b%b%b want 000", oe_a, oe_b, dq_drive); end
  endtask

  task automatic test_single_write();
    goto_ce(0);
    ldr_addr = 22'h000010; ldr_data = 8'hA5; ldr_write = 1;
    tick(1);
    ldr_write = 0;
    checks++; if (fifo_empty !== 1'b0) begin errors++; $display("FAIL single_fifo_nonempty got %0b want 0", fifo_empty); end
    tick(1); tick(1);
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL single_we_early got %0b want 0", we); end
    tick(1);
    for (int i = 0; i < 4; i++) begin
      checks++; if (we !== 1'b1 || addr !== 25'h0000010 || din !== 8'hA5) begin
        errors++; $display("FAIL single_issue_cyc%0d got we=%0b addr=%h din=%h want 1/0000010/a5", i, we, addr, din);
      end
      tick(1);
    end
    checks++; if (we !== 1'b0 || fifo_empty !== 1'b1) begin errors++; $display("FAIL single_release got we=%0b empty=%0b want 0/1", we, fifo_empty); end
  endtask

  task automatic test_overflow();
    logic [29:0] exp;
    goto_ce(0);
    for (int i = 0; i < 5; i++) begin
      ldr_addr = 22'(32'h100 + i); ldr_data = 8'(32'h10 + i); ldr_write = 1;
      if (i < 4) exp_q.push_back({ldr_addr, ldr_data});
      tick(0);
      if (i == 3) begin
        checks++; if (ldr_overflow !== 1'b0) begin errors++; $display("FAIL ovf_at_full got %0b want 0", ldr_overflow); end
      end
    end
    ldr_write = 0;
    checks++; if (ldr_overflow !== 1'b1) begin errors++; $display("FAIL ovf_dropped got %0b want 1", ldr_overflow); end
    for (int k = 0; k < 4; k++) begin
      goto_ce(3); tick(1);
      exp = exp_q.pop_front();
      checks++; if (we !== 1'b1 || addr !== {3'b000, exp[29:8]} || din !== exp[7:0]) begin
        errors++; $display("FAIL ovf_issue%0d got we=%0b addr=%h din=%h want 1/%h/%h", k, we, addr, din, {3'b000, exp[29:8]}, exp[7:0]);
      end
    end
    goto_ce(3); tick(1);
    checks++; if (we !== 1'b0 || fifo_empty !== 1'b1 || ldr_overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_end got we=%0b empty=%0b ovf=%0b want 0/1/1", we, fifo_empty, ldr_overflow);
    end
  endtask

  task automatic test_push_pop_full();
    logic [29:0] exp;
    reset = 1; tick(0); reset = 0; ce_phase = 0;
    for (int i = 0; i < 4; i++) begin
      ldr_addr = 22'(32'h200 + i); ldr_data = 8'(32'h20 + i); ldr_write = 1;
      exp_q.push_back({ldr_addr, ldr_data});
      tick(0);
    end
    ce_phase = 3;
    ldr_addr = 22'h000204; ldr_data = 8'h24; ldr_write = 1;
    exp_q.push_back({ldr_addr, ldr_data});
    tick(1);
    ldr_write = 0;
    checks++; if (ldr_overflow !== 1'b0) begin errors++; $display("FAIL pp_no_overflow got %0b want 0", ldr_overflow); end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin goto_ce(3); tick(1); end
      exp = exp_q.pop_front();
      checks++; if (we !== 1'b1 || addr !== {3'b000, exp[29:8]} || din !== exp[7:0]) begin
        errors++; $display("FAIL pp_issue%0d got we=%0b addr=%h din=%h want 1/%h/%h", k, we, addr, din, {3'b000, exp[29:8]}, exp[7:0]);
      end
    end
    goto_ce(3); tick(1);
    checks++; if (we !== 1'b0 || fifo_empty !== 1'b1) begin errors++; $display("FAIL pp_end got we=%0b empty=%0b want 0/1", we, fifo_empty); end
  endtask

  task automatic test_drain();
    logic [29:0] exp;
    goto_ce(0);
    for (int i = 0; i < 2; i++) begin
      ldr_addr = 22'(32'h300 + i); ldr_data = 8'(32'h31 + i); ldr_write = 1;
      exp_q.push_back({ldr_addr, ldr_data});
      tick(0);
    end
    ldr_write = 0;
    load_done = 1;
    tick(1);
    checks++; if (nes_reset !== 1'b1) begin errors++; $display("FAIL drain_held got %0b want 1", nes_reset); end
    for (int k = 0; k < 2; k++) begin
      goto_ce(3); tick(1);
      exp = exp_q.pop_front();
      checks++; if (we !== 1'b1 || addr !== {3'b000, exp[29:8]} || din !== exp[7:0] || nes_reset !== 1'b1) begin
        errors++; $display("FAIL drain_issue%0d got we=%0b addr=%h din=%h rst=%0b want 1/%h/%h/1", k, we, addr, din, nes_reset, {3'b000, exp[29:8]}, exp[7:0]);
      end
    end
    goto_ce(3);
    checks++; if (nes_reset !== 1'b1 || we !== 1'b1) begin errors++; $display("FAIL drain_last_slot got rst=%0b we=%0b want 1/1", nes_reset, we); end
    tick(1);
    checks++; if (nes_reset !== 1'b0 || we !== 1'b0) begin errors++; $display("FAIL drain_to_run got rst=%0b we=%0b want 0/0", nes_reset, we); end
    read_cpu = 1; #1;
    checks++; if (oe_a !== 1'b1 || oe_b !== 1'b0) begin errors++; $display("FAIL run_oea got %b%b want 10", oe_a, oe_b); end
    read_cpu = 0; read_ppu = 1; #1;
    checks++; if (oe_a !== 1'b0 || oe_b !== 1'b1) begin errors++; $display("FAIL run_oeb got %b%b want 01", oe_a, oe_b); end
    read_ppu = 0;
  endtask

  task automatic test_run_passthrough();
    nes_addr = 22'h3FFFFF; nes_dout = 8'h3C; nes_write = 1; #1;
    checks++; if (addr !== 25'h03FFFFF || we !== 1'b1 || dq_drive !== 1'b1 || din !== 8'h3C) begin
      errors++; $display("FAIL run_write got addr=%h we=%0b dq=%0b din=%h want 03fffff/1/1/3c", addr, we, dq_drive, din);
    end
    ldr_write = 1;
    for (int i = 0; i < 6; i++) tick(1);
    ldr_write = 0;
    checks++; if (fifo_empty !== 1'b1 || ldr_overflow !== 1'b0 || nes_reset !== 1'b0) begin
      errors++; $display("FAIL run_ldr_ignored got empty=%0b ovf=%0b rst=%0b want 1/0/0", fifo_empty, ldr_overflow, nes_reset);
    end
    nes_write = 0; #1;
    checks++; if (we !== 1'b0 || dq_drive !== 1'b0) begin errors++; $display("FAIL run_write_off got we=%0b dq=%0b want 0/0", we, dq_drive); end
  endtask

  task automatic test_reload_and_reset();
    load_done = 0;
    tick(1);
    checks++; if (nes_reset !== 1'b1 || we !== 1'b0) begin errors++; $display("FAIL reload got rst=%0b we=%0b want 1/0", nes_reset, we); end
    goto_ce(0);
    ldr_addr = 22'h000400; ldr_data = 8'h41; ldr_write = 1; tick(1);
    ldr_addr = 22'h000401; ldr_data = 8'h42; tick(1);
    ldr_write = 0;
    goto_ce(3); tick(1);
    checks++; if (we !== 1'b1 || addr !== 25'h0000400 || din !== 8'h41) begin
      errors++; $display("FAIL reload_issue got we=%0b addr=%h din=%h want 1/0000400/41", we, addr, din);
    end
    reset = 1; tick(1); reset = 0;
    checks++; if (we !== 1'b0 || fifo_empty !== 1'b1 || nes_reset !== 1'b1 || dq_drive !== 1'b0 || ldr_overflow !== 1'b0) begin
      errors++; $display("FAIL midwrite_reset got we=%0b empty=%0b rst=%0b dq=%0b ovf=%0b want 0/1/1/0/0", we, fifo_empty, nes_reset, dq_drive, ldr_overflow);
    end
  endtask

  // sequence and report
  initial begin
    test_reset();
    test_single_write();
    test_overflow();
    test_push_pop_full();
    test_drain();
    test_run_passthrough();
    test_reload_and_reset();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
